adpll_lock_ctrl: RTL and testbench
==================================

ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 Parameter BIAS, default 12'd154: free-running DCO control word used while the loop is open.
REQ-002 Parameter ERR_W, default 8: phase-error width, two's complement.
REQ-003 Parameters SETTLE_SAMPLES=16, LOCK_THRESH=4, LOCK_COUNT=32, UNLOCK_THRESH=16, UNLOCK_COUNT=4, TIMEOUT_SAMPLES=1024: thresholds and counts, in error samples.
REQ-004 clk_i  in  1  single block clock, rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 enable_i  in  1  level; loop runs while 1.
REQ-007 phase_err_i  in  ERR_W  signed phase-detector error.
REQ-008 phase_err_valid_i  in  1  one-cycle strobe per reference edge; qualifies phase_err_i.
REQ-009 filter_word_i  in  12  loop-filter DCO word.
REQ-010 dco_ctrl_o  out  12  registered DCO control word.
REQ-011 filter_clr_o  out  1  clears loop-filter integrator.
REQ-012 gain_sel_o  out  2  loop-gain select: 00 off, 10 acquire (high), 01 track (low).
REQ-013 state_o  out  2  FSM state: 00 IDLE, 01 SETTLE, 10 ACQUIRE, 11 TRACK.
REQ-014 locked_o  out  1  level; 1 only in TRACK.
REQ-015 lock_lost_o  out  1  one-cycle pulse on TRACK->ACQUIRE.
REQ-016 timeout_o  out  1  one-cycle pulse on acquisition timeout.

Function
REQ-017 |err| SHALL be computed at ERR_W+1 bits; the most negative input (-128 for ERR_W=8) yields magnitude 128, with no wrap.
REQ-018 "In window" SHALL mean |err| <= LOCK_THRESH; "out of window" SHALL mean |err| > UNLOCK_THRESH; equality to a threshold counts as in window and not out of window, respectively.
REQ-019 Counters SHALL advance only on cycles with phase_err_valid_i=1 and SHALL saturate, never wrap.
REQ-020 IDLE: dco_ctrl_o=BIAS, filter_clr_o=1, gain_sel_o=00; on enable_i=1 -> SETTLE next cycle.
REQ-021 SETTLE: dco_ctrl_o=BIAS, filter_clr_o=1, gain_sel_o=00; after SETTLE_SAMPLES valid strobes -> ACQUIRE.
REQ-022 ACQUIRE: filter_clr_o=0, gain_sel_o=10, dco_ctrl_o=filter_word_i registered (1-cycle latency); consecutive in-window counter resets to 0 on any valid sample not in window; reaching LOCK_COUNT -> TRACK.
REQ-023 TRACK: gain_sel_o=01, locked_o=1, dco_ctrl_o as in ACQUIRE; consecutive out-of-window counter resets on any valid sample not out of window; reaching UNLOCK_COUNT -> ACQUIRE with lock_lost_o=1 for exactly one cycle, locked_o=0 the same cycle.
REQ-024 Every state transition SHALL clear all sample counters.
REQ-025 enable_i=0 in any state SHALL force IDLE on the next edge, taking priority over a simultaneous valid strobe or transition; locked_o drops the same edge, no lock_lost_o pulse.
REQ-026 gain_sel_o SHALL change on the same edge as state_o, never glitching through another code.

Reset
REQ-027 rst_i=1 at a clock edge SHALL, regardless of state, set state_o=00, dco_ctrl_o=BIAS, filter_clr_o=1, gain_sel_o=00, locked_o=0, lock_lost_o=0, timeout_o=0, all counters 0.
REQ-028 Reset SHALL take priority over enable_i and phase_err_valid_i; the first non-reset edge evaluates enable_i normally.

Configuration
REQ-029 Macro ADPLL_LOCK_TIMEOUT_EN defined: a per-ACQUIRE valid-sample counter; reaching TIMEOUT_SAMPLES without entering TRACK -> SETTLE, timeout_o=1 for one cycle, filter cleared.
REQ-030 Macro undefined: no timeout counter synthesised, timeout_o tied 0, ACQUIRE persists until lock or enable_i=0.

Verification
REQ-031 Reset asserted 3 cycles mid-TRACK -> state 00, dco_ctrl_o=154, locked_o=0 after first edge.
REQ-032 enable_i=1, 16 strobes with err=+50 -> SETTLE holds dco_ctrl_o=154; 16th strobe -> ACQUIRE, gain_sel_o=10, filter_clr_o=0.
REQ-033 In ACQUIRE: 31 strobes err=+4, one err=-5, then 32 strobes err=-4 -> TRACK only after the final 32nd, locked_o=1.
REQ-034 In TRACK: 3 strobes err=+17, one err=+16, 4 strobes err=-128 -> one lock_lost_o pulse after the 4th -128, state 10.
REQ-035 With ADPLL_LOCK_TIMEOUT_EN, 1024 strobes err=+100 in ACQUIRE -> timeout_o pulse, state 01; without macro -> stays 10, timeout_o=0.
REQ-036 enable_i dropped on the same cycle as the LOCK_COUNT-th in-window strobe -> IDLE, locked_o never asserts.

Source files
------------

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl
// Lock-detection and loop-sequencing controller for an all-digital PLL.
// It holds the DCO at a free-running bias word while the loop is open. After a
// settling interval it closes the loop with high gain (ACQUIRE). Once the phase
// error has stayed inside a narrow window long enough, it drops to low gain
// (TRACK). It reopens acquisition if the error stays outside a wider window.
//
// Optional feature: define ADPLL_LOCK_TIMEOUT_EN to enable an acquisition
// timeout. On timeout the controller returns to SETTLE and pulses timeout_o.
// Without the macro, timeout_o is tied low and no timeout counter is built.
//
// Ports:
//   clk_i             in   rising-edge clock
//   rst_i             in   synchronous active-high reset
//   enable_i          in   loop runs while high; low forces IDLE
//   phase_err_i       in   signed phase-detector error (ERR_W bits)
//   phase_err_valid_i in   one-cycle strobe qualifying phase_err_i
//   filter_word_i     in   loop-filter DCO word (12 bits)
//   dco_ctrl_o        out  registered DCO control word (12 bits)
//   filter_clr_o      out  holds the loop-filter integrator clear
//   gain_sel_o        out  00 off, 10 acquire (high), 01 track (low)
//   state_o           out  00 IDLE, 01 SETTLE, 10 ACQUIRE, 11 TRACK
//   locked_o          out  high only while in TRACK
//   lock_lost_o       out  one-cycle pulse on TRACK -> ACQUIRE
//   timeout_o         out  one-cycle pulse on acquisition timeout
module adpll_lock_ctrl #(
  parameter logic [11:0] BIAS            = 12'd154,
  parameter int          ERR_W           = 8,
  parameter int          SETTLE_SAMPLES  = 16,
  parameter int          LOCK_THRESH     = 4,
  parameter int          LOCK_COUNT      = 32,
  parameter int          UNLOCK_THRESH   = 16,
  parameter int          UNLOCK_COUNT    = 4,
  parameter int          TIMEOUT_SAMPLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [ERR_W-1:0] phase_err_i,
  input  logic             phase_err_valid_i,
  input  logic [11:0]      filter_word_i,
  output logic [11:0]      dco_ctrl_o,
  output logic             filter_clr_o,
  output logic [1:0]       gain_sel_o,
  output logic [1:0]       state_o,
  output logic             locked_o,
  output logic             lock_lost_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    ACQUIRE = 2'b10,
    TRACK   = 2'b11
  } state_t;

  localparam int SC_W = $clog2(SETTLE_SAMPLES + 1);
  localparam int LC_W = $clog2(LOCK_COUNT + 1);
  localparam int UC_W = $clog2(UNLOCK_COUNT + 1);

  // Each counter's transition fires on the sample that would reach its target.
  // So a counter only ever holds values up to target-1 and cannot wrap.
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_SAMPLES - 1);
  localparam logic [LC_W-1:0]  LOCK_LAST   = LC_W'(LOCK_COUNT - 1);
  localparam logic [UC_W-1:0]  UNLOCK_LAST = UC_W'(UNLOCK_COUNT - 1);
  localparam logic [ERR_W:0]   LOCK_TH     = (ERR_W + 1)'(LOCK_THRESH);
  localparam logic [ERR_W:0]   UNLOCK_TH   = (ERR_W + 1)'(UNLOCK_THRESH);

`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [TC_W-1:0] TIMEOUT_LAST = TC_W'(TIMEOUT_SAMPLES - 1);
  logic [TC_W-1:0] to_cnt, to_cnt_nxt;
  logic            to_pulse_nxt;
`endif

  state_t          state, state_nxt;
  logic [SC_W-1:0] settle_cnt, settle_nxt;
  logic [LC_W-1:0] lock_cnt, lock_nxt;
  logic [UC_W-1:0] unlock_cnt, unlock_nxt;
  logic            lost_nxt;
  logic [11:0]     dco_nxt;
  logic            clr_nxt;
  logic [1:0]      gain_nxt;
  logic            locked_nxt;

  // The magnitude is one bit wider than the error.
  // This keeps the most negative input representable instead of wrapping.
  logic [ERR_W:0] err_ext, err_mag;
  logic           in_win, out_win;

  assign err_ext = {phase_err_i[ERR_W-1], phase_err_i};
  assign err_mag = err_ext[ERR_W] ? (~err_ext + 1'b1) : err_ext;
  assign in_win  = (err_mag <= LOCK_TH);
  assign out_win = (err_mag > UNLOCK_TH);

  assign state_o = state;

  // Next-state, counter and output decode.
  // enable_i low overrides every other condition.
  // Outputs are decoded from the next state and then registered. This makes
  // gain_sel_o, filter_clr_o and locked_o change on the same edge as state_o.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    lock_nxt   = lock_cnt;
    unlock_nxt = unlock_cnt;
    lost_nxt   = 1'b0;
`ifdef ADPLL_LOCK_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
    to_pulse_nxt = 1'b0;
`endif

    if (!enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = SETTLE;
        SETTLE: begin
          if (phase_err_valid_i) begin
            if (settle_cnt == SETTLE_LAST) state_nxt = ACQUIRE;
            else                           settle_nxt = settle_cnt + 1'b1;
          end
        end
        ACQUIRE: begin
          if (phase_err_valid_i) begin
            if (!in_win)                   lock_nxt  = '0;
            else if (lock_cnt == LOCK_LAST) state_nxt = TRACK;
            else                           lock_nxt  = lock_cnt + 1'b1;
`ifdef ADPLL_LOCK_TIMEOUT_EN
            // Reaching lock on the final allowed sample wins over timing out.
            if (state_nxt != TRACK) begin
              if (to_cnt == TIMEOUT_LAST) begin
                state_nxt    = SETTLE;
                to_pulse_nxt = 1'b1;
              end else begin
                to_cnt_nxt = to_cnt + 1'b1;
              end
            end
`endif
          end
        end
        TRACK: begin
          if (phase_err_valid_i) begin
            if (!out_win) begin
              unlock_nxt = '0;
            end else if (unlock_cnt == UNLOCK_LAST) begin
              state_nxt = ACQUIRE;
              lost_nxt  = 1'b1;
            end else begin
              unlock_nxt = unlock_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Every state change starts the destination state with fresh counters.
    if (state_nxt != state) begin
      settle_nxt = '0;
      lock_nxt   = '0;
      unlock_nxt = '0;
`ifdef ADPLL_LOCK_TIMEOUT_EN
      to_cnt_nxt = '0;
`endif
    end

    dco_nxt    = BIAS;
    clr_nxt    = 1'b1;
    gain_nxt   = 2'b00;
    locked_nxt = 1'b0;
    case (state_nxt)
      ACQUIRE: begin
        dco_nxt  = filter_word_i;
        clr_nxt  = 1'b0;
        gain_nxt = 2'b10;
      end
      TRACK: begin
        dco_nxt    = filter_word_i;
        clr_nxt    = 1'b0;
        gain_nxt   = 2'b01;
        locked_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      unlock_cnt   <= '0;
      dco_ctrl_o   <= BIAS;
      filter_clr_o <= 1'b1;
      gain_sel_o   <= 2'b00;
      locked_o     <= 1'b0;
      lock_lost_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_nxt;
      lock_cnt     <= lock_nxt;
      unlock_cnt   <= unlock_nxt;
      dco_ctrl_o   <= dco_nxt;
      filter_clr_o <= clr_nxt;
      gain_sel_o   <= gain_nxt;
      locked_o     <= locked_nxt;
      lock_lost_o  <= lost_nxt;
    end
  end

`ifdef ADPLL_LOCK_TIMEOUT_EN
  // Acquisition timeout counter and its one-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      timeout_o <= to_pulse_nxt;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb_adpll_lock_ctrl
// Self-checking bench for adpll_lock_ctrl.
// The first part applies a small vector table with constant expectations.
// Hand-written sequences then cover settle, lock, unlock, timeout, the enable
// race and reset-in-TRACK. A randomized run is checked every cycle against a
// behavioural model. The model counts samples with plain integers and applies
// the window/threshold rules directly.
module tb_adpll_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [7:0]  phase_err_i;
  logic        phase_err_valid_i;
  logic [11:0] filter_word_i;
  logic [11:0] dco_ctrl_o;
  logic        filter_clr_o;
  logic [1:0]  gain_sel_o;
  logic [1:0]  state_o;
  logic        locked_o;
  logic        lock_lost_o;
  logic        timeout_o;

`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  adpll_lock_ctrl dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .phase_err_i       (phase_err_i),
    .phase_err_valid_i (phase_err_valid_i),
    .filter_word_i     (filter_word_i),
    .dco_ctrl_o        (dco_ctrl_o),
    .filter_clr_o      (filter_clr_o),
    .gain_sel_o        (gain_sel_o),
    .state_o           (state_o),
    .locked_o          (locked_o),
    .lock_lost_o       (lock_lost_o),
    .timeout_o         (timeout_o)
  );

  int total = 0;
  int bad   = 0;
  int fw_cur = 0;

  // Model: state number 0..3 and plain integer sample tallies.
  int m_state = 0, m_settle = 0, m_run = 0, m_outrun = 0, m_tout = 0;
  int m_dco = 154;
  bit m_lost = 1'b0, m_to = 1'b0;

  typedef struct {
    bit rst; bit en; bit valid; int err; int fw;
    int st; int dco; int gain; int clr; int locked;
  } vec_t;
  vec_t vecs[8];

  // Advance the model by one clock edge using the rules directly.
  task automatic modelStep(input bit rst, input bit en, input bit valid,
                           input int err, input int fw);
    int mag, nxt;
    bit inw, outw, lost, to;
    mag  = (err < 0) ? -err : err;
    inw  = (mag <= 4);
    outw = (mag > 16);
    nxt  = m_state;
    lost = 1'b0;
    to   = 1'b0;
    if (rst || !en) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: if (valid) begin
             m_settle++;
             if (m_settle >= 16) nxt = 2;
           end
        2: if (valid) begin
             m_run = inw ? m_run + 1 : 0;
             m_tout++;
             if (m_run >= 32) nxt = 3;
             else if (TO_EN && m_tout >= 1024) begin nxt = 1; to = 1'b1; end
           end
        3: if (valid) begin
             m_outrun = outw ? m_outrun + 1 : 0;
             if (m_outrun >= 4) begin nxt = 2; lost = 1'b1; end
           end
        default: nxt = 0;
      endcase
    end
    if (rst || nxt != m_state) begin
      m_settle = 0; m_run = 0; m_outrun = 0; m_tout = 0;
    end
    m_state = nxt;
    m_dco   = (nxt >= 2) ? fw : 154;
    m_lost  = lost;
    m_to    = to;
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit valid,
                               input int err, input int fw);
    rst_i             = rst;
    enable_i          = en;
    phase_err_valid_i = valid;
    phase_err_i       = 8'(err);
    filter_word_i     = 12'(fw);
    @(posedge clk);
    modelStep(rst, en, valid, err, fw);
    #1;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string name);
    logic [19:0] act, exp;
    logic [1:0]  g;
    g   = (m_state == 2) ? 2'b10 : (m_state == 3) ? 2'b01 : 2'b00;
    exp = {2'(m_state), 12'(m_dco), (m_state < 2), g, (m_state == 3), m_lost, m_to};
    act = {state_o, dco_ctrl_o, filter_clr_o, gain_sel_o, locked_o, lock_lost_o, timeout_o};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (state,dco,clr,gain,locked,lost,to) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input int err, input string name);
    applyStimulus(1'b0, 1'b1, 1'b1, err, fw_cur);
    checkOutput(name);
  endtask

  task automatic resetAndSettle();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    checkOutput("reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
    checkOutput("to_settle");
  endtask

  task automatic goAcquire();
    resetAndSettle();
    for (int i = 0; i < 16; i++) strobe(50, "settle_strobe");
  endtask

  task automatic goTrack();
    goAcquire();
    for (int i = 0; i < 32; i++) strobe(0, "lock_strobe");
  endtask

  initial begin
    int mode, err;
    bit r, e, v;

    rst_i = 1'b1; enable_i = 1'b0; phase_err_valid_i = 1'b0;
    phase_err_i = '0; filter_word_i = '0;
    @(posedge clk);
    #1;

    // Vector table: reset, enable priority, reset priority.
    vecs[0] = '{1, 1, 1, 50, 1445, 0, 154, 0, 1, 0};
    vecs[1] = '{0, 0, 0, 0,  1445, 0, 154, 0, 1, 0};
    vecs[2] = '{0, 1, 0, 0,  1445, 1, 154, 0, 1, 0};
    vecs[3] = '{0, 1, 1, 50, 1445, 1, 154, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 3,  1445, 0, 154, 0, 1, 0};
    vecs[5] = '{0, 1, 1, 3,  1445, 1, 154, 0, 1, 0};
    vecs[6] = '{1, 1, 1, 3,  1445, 0, 154, 0, 1, 0};
    vecs[7] = '{0, 1, 0, 0,  1445, 1, 154, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].err, vecs[i].fw);
      checkVal("vec_state",  state_o,      vecs[i].st);
      checkVal("vec_dco",    dco_ctrl_o,   vecs[i].dco);
      checkVal("vec_gain",   gain_sel_o,   vecs[i].gain);
      checkVal("vec_clr",    filter_clr_o, vecs[i].clr);
      checkVal("vec_locked", locked_o,     vecs[i].locked);
      checkOutput("vec_model");
    end

    // Settle: 16 strobes with idle gaps, DCO held at bias until the last.
    fw_cur = 939;
    resetAndSettle();
    for (int i = 1; i <= 16; i++) begin
      strobe(50, "settle");
      if (i < 16) begin
        checkVal("settle_hold_dco", dco_ctrl_o, 154);
        checkVal("settle_hold_state", state_o, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
        checkOutput("settle_gap");
      end
    end
    checkVal("acq_state", state_o, 2);
    checkVal("acq_gain", gain_sel_o, 2);
    checkVal("acq_clr", filter_clr_o, 0);
    checkVal("acq_dco", dco_ctrl_o, 939);
    fw_cur = 291;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
    checkVal("acq_dco_follow", dco_ctrl_o, 291);

    // Lock: a single out-of-window sample restarts the in-window run.
    for (int i = 0; i < 31; i++) strobe(4, "lock_run1");
    checkVal("lock_run1_state", state_o, 2);
    strobe(-5, "lock_break");
    for (int i = 0; i < 31; i++) strobe(-4, "lock_run2");
    checkVal("lock_pre_state", state_o, 2);
    checkVal("lock_pre_locked", locked_o, 0);
    strobe(-4, "lock_final");
    checkVal("track_state", state_o, 3);
    checkVal("track_locked", locked_o, 1);
    checkVal("track_gain", gain_sel_o, 1);

    // Unlock: +16 is not out of window; -128 has magnitude 128.
    for (int i = 0; i < 3; i++) strobe(17, "unlock_17");
    strobe(16, "unlock_16");
    for (int i = 0; i < 3; i++) strobe(-128, "unlock_m128");
    checkVal("unlock_pre_state", state_o, 3);
    checkVal("unlock_pre_lost", lock_lost_o, 0);
    strobe(-128, "unlock_final");
    checkVal("unlock_state", state_o, 2);
    checkVal("unlock_lost", lock_lost_o, 1);
    checkVal("unlock_locked", locked_o, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
    checkVal("unlock_lost_pulse", lock_lost_o, 0);

    // Acquisition timeout (or its absence).
    for (int i = 0; i < 1023; i++) strobe(100, "timeout_run");
    checkVal("timeout_pre_state", state_o, 2);
    strobe(100, "timeout_final");
    checkVal("timeout_state", state_o, TO_EN ? 1 : 2);
    checkVal("timeout_pulse", timeout_o, TO_EN ? 1 : 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
    checkVal("timeout_pulse_end", timeout_o, 0);

    // enable_i drops on the lock-completing strobe.
    goAcquire();
    for (int i = 0; i < 31; i++) strobe(0, "race_run");
    applyStimulus(1'b0, 1'b0, 1'b1, 0, fw_cur);
    checkOutput("race_drop");
    checkVal("race_state", state_o, 0);
    checkVal("race_locked", locked_o, 0);
    checkVal("race_lost", lock_lost_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, fw_cur);
    checkVal("race_locked_after", locked_o, 0);

    // Reset held three cycles from TRACK.
    goTrack();
    checkVal("rst_track_state", state_o, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 0, fw_cur);
      checkOutput("rst_in_track");
    end
    checkVal("rst_state", state_o, 0);
    checkVal("rst_dco", dco_ctrl_o, 154);
    checkVal("rst_locked", locked_o, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, fw_cur);
    checkVal("rst_release_state", state_o, 1);

    // Randomized run against the model, error spread changing per segment.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) mode = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 399) == 0);
      e = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 1) == 1);
      case (mode)
        0:       err = int'($urandom_range(0, 8)) - 4;
        1:       err = int'($urandom_range(0, 40)) - 20;
        default: err = int'($urandom_range(0, 255)) - 128;
      endcase
      fw_cur = int'($urandom_range(0, 4095));
      applyStimulus(r, e, v, err, fw_cur);
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
